arf_multiport: RTL and testbench
================================

Name: arf_multiport

Overview:
- Parametrised architectural register file, successor to the single-write, two-read register bank in the I2OI pipeline.
- Configurable width, depth, and numbers of read and write ports.
- Write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard used by issue logic.
- A post-reset init sequencer loads register i with value i, one register per cycle, then raises ready.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of two, >= 2)
- AW, $clog2(DEPTH), address width (derived; do not override)
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write ports
- ZERO_REG, 0, if 1 then register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  packed read data (combinational)
- rd_busy  out  NUM_RD  busy bit of each read address (combinational)
- wr_en  in  NUM_WR  write enable per write port
- wr_addr  in  NUM_WR*AW  packed write addresses
- wr_data  in  NUM_WR*WIDTH  packed write data
- iss_valid  in  1  mark iss_dst busy
- iss_dst  in  AW  destination register being issued
- ready  out  1  high when init is complete and writes/issues are accepted

Behaviour:
- State machine states: INIT, RUN.
  - rst_n low: state=INIT, init_cnt=0, all busy bits=0, ready=0. Memory contents are not reset.
  - INIT, each cycle: mem[init_cnt] <= init_cnt, zero-extended or truncated to WIDTH; init_cnt++.
  - At init_cnt==DEPTH-1 the final write occurs and state -> RUN.
  - ready=1 from the first RUN cycle, i.e. DEPTH cycles after rst_n deasserts.
  - In INIT: wr_en and iss_valid are ignored; rd_data reflects raw memory; rd_busy=0.
  - Reset asserted mid-RUN: immediate return to INIT, scoreboard cleared, re-init from 0.
- Writes (RUN only): write port w with wr_en[w]=1 updates mem[wr_addr_w] at posedge.
  - Several ports to the same address in one cycle: highest-indexed port wins.
  - ZERO_REG=1 and address 0: the write is dropped.
- Reads, per port, combinational:
  - If ZERO_REG=1 and address 0: output 0.
  - Else if any enabled write in RUN targets the same address: output the data of the highest-indexed matching port (bypass).
  - Else: output mem[addr].
- Scoreboard busy[DEPTH] (RUN only):
  - An enabled write to r clears busy[r].
  - iss_valid sets busy[iss_dst].
  - Set and clear of the same r in the same cycle: set wins (newer producer).
  - ZERO_REG=1: busy[0] is held at 0.
- rd_busy[p] = busy[addr_p] AND NOT(an enabled write to addr_p this cycle). A same-cycle set by iss_valid is not visible until the next cycle.
- No other latency: write-to-read is 0 cycles via bypass; issue-to-busy is 1 cycle.

Decomposition:
- Shared package arf_pkg holds the state enum (ARF_INIT, ARF_RUN) and default WIDTH/DEPTH constants reused by the pipeline.
- One natural sub-module: arf_wr_select, the priority match over write ports, returning hit flag and data for a given address. It is instantiated once per read port and reused for the memory update.

Test Plan:
- Init: release rst_n, hold wr_en=1 (addr 5, data 0xFFFF) -> ready low for exactly 32 cycles, then rd_addr=5 reads 5, rd_addr=31 reads 31 (the write was ignored).
- Bypass and persist: RUN, wr_en[0]=1 addr 7 data 0xDEADBEEF, rd_addr port0=7 -> same-cycle rd_data=0xDEADBEEF; next cycle with wr_en=0 still 0xDEADBEEF.
- Write conflict (NUM_WR=2): both ports write addr 3 (0x11 on port 0, 0x22 on port 1) -> bypass and stored value both 0x22.
- Scoreboard:
  - iss_valid dst 9 -> rd_busy=1 next cycle.
  - Write to 9 -> rd_busy=0 in that same cycle, busy bit cleared after the edge.
  - Simultaneous iss_valid dst 9 and write to 9 -> busy stays 1.
- ZERO_REG=1: write 0x55 to r0 and iss_valid dst 0 -> rd_data=0 and rd_busy=0, including during the write cycle.
- Reset mid-run: set busy on r4 and write r4=0x99, pulse rst_n low for 1 cycle -> ready=0, busy cleared, after 32 cycles r4 reads 4.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared definitions for the architectural register file: sequencer states
// and the default geometry used by the surrounding pipeline.
package arf_pkg;

  typedef enum logic {
    ARF_INIT = 1'b0,
    ARF_RUN  = 1'b1
  } arf_state_e;

  localparam int ARF_WIDTH = 32;
  localparam int ARF_DEPTH = 32;

endpackage

// File: rtl/arf_wr_select.sv
// Priority match of one address against all write ports; the highest-indexed
// enabled port that targets the address supplies the data.
module arf_wr_select #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int NUM_WR = 1
) (
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [AW-1:0]           addr,
  output logic                    hit,
  output logic [WIDTH-1:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan so later (higher-indexed) matches overwrite earlier ones.
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[w*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/arf_multiport.sv
// Multi-port architectural register file with write-to-read bypass, optional
// zero register, per-register busy scoreboard and a post-reset init sequencer.
module arf_multiport
  import arf_pkg::*;
#(
  parameter int WIDTH    = ARF_WIDTH,
  parameter int DEPTH    = ARF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_dst,
  output logic                    ready
);

  arf_state_e       state_q, state_d;
  logic [AW-1:0]    init_cnt_q, init_cnt_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [NUM_WR-1:0] wr_en_run;
  logic [DEPTH-1:0]  reg_hit;
  logic [WIDTH-1:0]  reg_hit_data [DEPTH];

  // Writes only exist once the sequencer has finished; this also kills bypass in INIT.
  assign wr_en_run = (state_q == ARF_RUN) ? wr_en : '0;
  assign ready     = (state_q == ARF_RUN);

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg_sel
    arf_wr_select #(.WIDTH(WIDTH), .AW(AW), .NUM_WR(NUM_WR)) u_sel (
      .wr_en   (wr_en_run),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (AW'(r)),
      .hit     (reg_hit[r]),
      .data    (reg_hit_data[r])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [AW-1:0]    addr;
    logic             hit;
    logic [WIDTH-1:0] hit_data;

    assign addr = rd_addr[p*AW +: AW];

    arf_wr_select #(.WIDTH(WIDTH), .AW(AW), .NUM_WR(NUM_WR)) u_sel (
      .wr_en   (wr_en_run),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (addr),
      .hit     (hit),
      .data    (hit_data)
    );

    assign rd_data[p*WIDTH +: WIDTH] = ((ZERO_REG != 0) && (addr == '0)) ? '0 :
                                       hit ? hit_data : mem_q[addr];
    assign rd_busy[p] = busy_q[addr] & ~hit;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ARF_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(DEPTH - 1)) state_d = ARF_RUN;
      end
      ARF_RUN: state_d = ARF_RUN;
    endcase
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r]  = mem_q[r];
      busy_d[r] = busy_q[r];
      if (state_q == ARF_INIT) begin
        if (init_cnt_q == AW'(r)) mem_d[r] = WIDTH'(r);
      end else begin
        if (reg_hit[r]) begin
          if (!((ZERO_REG != 0) && (r == 0))) mem_d[r] = reg_hit_data[r];
          busy_d[r] = 1'b0;
        end
        // A new producer issued this cycle outranks the retiring write.
        if (iss_valid && (iss_dst == AW'(r))) busy_d[r] = 1'b1;
      end
      if ((ZERO_REG != 0) && (r == 0)) busy_d[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARF_INIT;
      init_cnt_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Storage is deliberately not reset; the sequencer gives it defined contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_arf_multiport.sv
// Randomized and directed bench for arf_multiport (2 read, 2 write ports, zero register on).
module tb_arf_multiport;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*W-1:0]  wr_data;
  logic             iss_valid;
  logic [AW-1:0]    iss_dst;
  logic             ready;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, busy flags, init progress.
  logic [W-1:0] mem_m [D];
  bit           busy_m [D];
  bit           ready_m;
  int           init_idx;

  always #5 clk = ~clk;

  arf_multiport #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .ready     (ready)
  );

  // ---------------- model ----------------
  task automatic model_reset();
    ready_m  = 1'b0;
    init_idx = 0;
    for (int r = 0; r < D; r++) busy_m[r] = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (a == 0) return '0;
    v = mem_m[a];
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*W +: W];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    bit b;
    b = ready_m && busy_m[a] && (a != 0);
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) b = 1'b0;
    return b;
  endfunction

  // One clock edge; the model takes the inputs that were present at the edge.
  task automatic tick();
    logic [AW-1:0] a;
    @(posedge clk);
    if (rst_n) begin
      if (!ready_m) begin
        mem_m[init_idx] = W'(init_idx);
        init_idx++;
        if (init_idx == D) ready_m = 1'b1;
      end else begin
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w]) begin
            a = wr_addr[w*AW +: AW];
            busy_m[a] = 1'b0;
            if (a != 0) mem_m[a] = wr_data[w*W +: W];
          end
        end
        if (iss_valid) busy_m[iss_dst] = 1'b1;
        busy_m[0] = 1'b0;
      end
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    wr_en     = '0;
    iss_valid = 1'b0;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en[w]            = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*W +: W]   = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready); end
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b expected 00", rd_busy); end
  endtask

  task automatic test_init();
    int n;
    set_wr(0, 5'd5, 32'h0000_FFFF);
    iss_valid = 1'b1;
    iss_dst   = 5'd5;
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    idle();
    #1;
    checks++;
    if (n != D) begin errors++; $display("FAIL init_latency got %0d expected %0d", n, D); end
    checks++;
    if (rd_data[W-1:0] !== 32'd5) begin errors++; $display("FAIL init_r5 got %h expected 5", rd_data[W-1:0]); end
    checks++;
    if (rd_data[2*W-1:W] !== 32'd31) begin errors++; $display("FAIL init_r31 got %h expected 1f", rd_data[2*W-1:W]); end
    checks++;
    if (rd_busy !== 2'b00) begin errors++; $display("FAIL init_busy got %b expected 00", rd_busy); end
  endtask

  task automatic test_bypass();
    set_wr(0, 5'd7, 32'hDEAD_BEEF);
    set_rd(0, 5'd7);
    set_rd(1, 5'd8);
    #1;
    checks++;
    if (rd_data[W-1:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same got %h expected deadbeef", rd_data[W-1:0]); end
    checks++;
    if (rd_data[2*W-1:W] !== exp_data(5'd8)) begin errors++; $display("FAIL bypass_other got %h expected %h", rd_data[2*W-1:W], exp_data(5'd8)); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[W-1:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_persist got %h expected deadbeef", rd_data[W-1:0]); end
  endtask

  task automatic test_conflict();
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd3, 32'h22);
    set_rd(0, 5'd3);
    #1;
    checks++;
    if (rd_data[W-1:0] !== 32'h22) begin errors++; $display("FAIL conflict_bypass got %h expected 22", rd_data[W-1:0]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[W-1:0] !== 32'h22) begin errors++; $display("FAIL conflict_stored got %h expected 22", rd_data[W-1:0]); end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 5'd9);
    iss_valid = 1'b1;
    iss_dst   = 5'd9;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_issue_same got %b expected 0", rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_issue_next got %b expected 1", rd_busy[0]); end
    set_wr(1, 5'd9, 32'h1234);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_write_same got %b expected 0", rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_write_next got %b expected 0", rd_busy[0]); end
    set_wr(0, 5'd9, 32'h5678);
    iss_valid = 1'b1;
    iss_dst   = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b expected 1", rd_busy[0]); end
    checks++;
    if (rd_data[W-1:0] !== 32'h5678) begin errors++; $display("FAIL sb_data got %h expected 5678", rd_data[W-1:0]); end
  endtask

  task automatic test_zero();
    set_wr(0, 5'd0, 32'h55);
    iss_valid = 1'b1;
    iss_dst   = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL zero_during got %h/%b expected 0/00", rd_data, rd_busy); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL zero_after got %h/%b expected 0/00", rd_data, rd_busy); end
  endtask

  task automatic test_random(input int cycles);
    logic [AW-1:0] a;
    for (int c = 0; c < cycles; c++) begin
      for (int w = 0; w < NW; w++) begin
        wr_en[w] = ($urandom_range(0, 2) == 0);
        wr_addr[w*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, D-1)) : AW'($urandom_range(0, 7));
        wr_data[w*W +: W] = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_dst   = AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, D-1)) : AW'($urandom_range(0, 7));
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL rand_ready cycle %0d got %b expected 1", c, ready); end
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        checks++;
        if (rd_data[p*W +: W] !== exp_data(a)) begin
          errors++; $display("FAIL rand_data cycle %0d port %0d addr %0d got %h expected %h", c, p, a, rd_data[p*W +: W], exp_data(a));
        end
        checks++;
        if (rd_busy[p] !== exp_busy(a)) begin
          errors++; $display("FAIL rand_busy cycle %0d port %0d addr %0d got %b expected %b", c, p, a, rd_busy[p], exp_busy(a));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int n;
    idle();
    set_wr(0, 5'd4, 32'h99);
    iss_valid = 1'b1;
    iss_dst   = 5'd4;
    tick();
    idle();
    set_rd(0, 5'd4);
    #1;
    checks++;
    if (rd_data[W-1:0] !== 32'h99 || rd_busy[0] !== 1'b1) begin errors++; $display("FAIL mid_pre got %h/%b expected 99/1", rd_data[W-1:0], rd_busy[0]); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL mid_async got %b/%b expected 0/0", ready, rd_busy[0]); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    #1;
    checks++;
    if (n != D) begin errors++; $display("FAIL mid_latency got %0d expected %0d", n, D); end
    checks++;
    if (rd_data[W-1:0] !== 32'd4 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL mid_reinit got %h/%b expected 4/0", rd_data[W-1:0], rd_busy[0]); end
  endtask

  initial begin
    rst_n     = 1'b0;
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_dst   = '0;
    test_reset();
    test_init();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero();
    test_random(400);
    test_mid_reset();
    test_random(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
